alu_serial_seq: RTL

Bit-serial sequencer that sits directly upstream of the team's 1-bit ALU slice. It drives a single external slice one bit per clock and decodes the 4-bit ALU control into slice invert, operation and carry-in controls. It carries the slice's carry-out from bit to bit in a flop and assembles the WIDTH-bit result, zero, cout and overflow. It is the area-minimal alternative to the 32-slice ripple ALU, with identical arithmetic results at WIDTH+1 cycles latency.

---
 rtl/alu_serial_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Bit-serial sequencer for an external 1-bit ALU slice. Drives
//               the slice one bit per clock (LSB first), ripples the carry
//               through a flop, and assembles result/zero/cout/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ALU_control_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o,
   output logic             slice_a_o,
   output logic             slice_b_o,
   output logic             slice_less_o,
   output logic             slice_ainv_o,
   output logic             slice_binv_o,
   output logic             slice_cin_o,
   output logic [1:0]       slice_op_o,
   input  logic             slice_result_i,
   input  logic             slice_cout_i,
   input  logic             slice_set_i
);

   localparam int             IW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [3:0]       ctrl_q,   ctrl_d;
   logic [IW-1:0]    idx_q,    idx_d;
   logic             carry_q,  carry_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q,   zero_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;

   logic             supported;
   logic             arith;
   logic             is_slt;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] res_final;

   // Classify the captured control code
   always_comb begin
      supported = ctrl_q inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
      arith     = ctrl_q inside {OP_ADD, OP_SUB, OP_SLT};
      is_slt    = (ctrl_q == OP_SLT);
   end

   // Drive the slice only while running; unsupported codes run the slice as AND
   always_comb begin
      slice_a_o    = 1'b0;
      slice_b_o    = 1'b0;
      slice_cin_o  = 1'b0;
      slice_ainv_o = 1'b0;
      slice_binv_o = 1'b0;
      slice_op_o   = 2'b00;
      if (state_q == S_RUN) begin
         slice_a_o   = a_q[idx_q];
         slice_b_o   = b_q[idx_q];
         slice_cin_o = carry_q;
         if (supported) begin
            slice_ainv_o = ctrl_q[3];
            slice_binv_o = ctrl_q[2];
            slice_op_o   = ctrl_q[1:0];
         end
      end
   end

   // The LESS input is tied low; SLT patches bit 0 from the MSB set output
   assign slice_less_o = 1'b0;

   // Sequencing, operand capture and result assembly
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      ctrl_d    = ctrl_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      acc_d     = acc_q;
      result_d  = result_q;
      zero_d    = zero_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      acc_shift = {slice_result_i, acc_q[WIDTH-1:1]};
      res_final = acc_shift;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               a_d     = src1_i;
               b_d     = src2_i;
               ctrl_d  = ALU_control_i;
               idx_d   = '0;
               carry_d = ALU_control_i[2];
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d   = acc_shift;
            carry_d = slice_cout_i;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Raw adder MSB (set) goes to bit 0, not overflow-corrected
               if (is_slt)
                  res_final[0] = slice_set_i;
               if (!supported)
                  res_final = '0;
               result_d = res_final;
               zero_d   = (res_final == '0);
               cout_d   = arith & slice_cout_i;
               ovf_d    = arith & (carry_q ^ slice_cout_i);
               idx_d    = '0;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy_o     = (state_q == S_RUN);
   assign done_o     = (state_q == S_DONE);
   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;

endmodule
`default_nettype wire
